// File: rtl/video_timing_pkg.sv
// ============================================================
// video_timing_pkg : shared constants and state type for the
// SXGA raster timing block.  Rev 1.0
// ============================================================
`default_nettype none

package video_timing_pkg;

    // Wide enough for the largest axis total (1688 clocks per line)
    localparam int CNT_W = 11;

    localparam int SXGA_H_ACTIVE = 1280;
    localparam int SXGA_H_FP     = 48;
    localparam int SXGA_H_SYNC   = 112;
    localparam int SXGA_H_BP     = 248;
    localparam int SXGA_V_ACTIVE = 1024;
    localparam int SXGA_V_FP     = 1;
    localparam int SXGA_V_SYNC   = 3;
    localparam int SXGA_V_BP     = 38;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2
    } t_vt_state;

endpackage

`default_nettype wire

// File: rtl/timing_axis_decode.sv
// ============================================================
// timing_axis_decode : active / sync flags for one raster axis.
// Rev 1.0
// ============================================================
`default_nettype none

module timing_axis_decode #(
    parameter int CNT_W  = 11,
    parameter int ACTIVE = 1280,
    parameter int FP     = 48,
    parameter int SYNC   = 112,
    parameter int BP     = 248
) (
    input  logic [CNT_W-1:0] cnt,
    output logic             active,
    output logic             sync
);

    localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC);

    generate
        if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1 ||
            (ACTIVE + FP + SYNC + BP) > (1 << CNT_W)) begin : g_bad_params
            $error("timing_axis_decode: illegal axis parameters");
        end
    endgenerate

    assign active = (cnt < ACT_END);
    assign sync   = (cnt >= SYNC_START) && (cnt < SYNC_END);

endmodule

`default_nettype wire

// File: rtl/sxga_video_timing.sv
// ============================================================
// sxga_video_timing : frame-aligned raster timing generator with
// registered sync/de/coordinate outputs.  Rev 1.0
// ============================================================
`default_nettype none

module sxga_video_timing
    import video_timing_pkg::*;
#(
    parameter int   H_ACTIVE = SXGA_H_ACTIVE,
    parameter int   H_FP     = SXGA_H_FP,
    parameter int   H_SYNC   = SXGA_H_SYNC,
    parameter int   H_BP     = SXGA_H_BP,
    parameter int   V_ACTIVE = SXGA_V_ACTIVE,
    parameter int   V_FP     = SXGA_V_FP,
    parameter int   V_SYNC   = SXGA_V_SYNC,
    parameter int   V_BP     = SXGA_V_BP,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             frame_start,
    output logic             busy
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    localparam logic [1:0] ST_IDLE      = IDLE;
    localparam logic [1:0] ST_RUN       = RUN;
    localparam logic [1:0] ST_STOP_PEND = STOP_PEND;

    logic [1:0]       state;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             counting;
    logic             line_end;
    logic             frame_end;
    logic             h_active;
    logic             h_sync_on;
    logic             v_active;
    logic             v_sync_on;

    assign counting  = (state != ST_IDLE);
    assign line_end  = (h_cnt == H_LAST);
    assign frame_end = line_end && (v_cnt == V_LAST);

    timing_axis_decode #(
        .CNT_W  (CNT_W),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_decode (
        .cnt    (h_cnt),
        .active (h_active),
        .sync   (h_sync_on)
    );

    timing_axis_decode #(
        .CNT_W  (CNT_W),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_decode (
        .cnt    (v_cnt),
        .active (v_active),
        .sync   (v_sync_on)
    );

    // A stop request seen on the very last clock of a frame ends it there
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!run) state <= frame_end ? ST_IDLE : ST_STOP_PEND;
                end
                ST_STOP_PEND: begin
                    if (run)            state <= ST_RUN;
                    else if (frame_end) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!counting) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (line_end) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else if (!counting) begin
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            hsync       <= h_sync_on ? SYNC_POL : ~SYNC_POL;
            vsync       <= v_sync_on ? SYNC_POL : ~SYNC_POL;
            de          <= h_active && v_active;
            x           <= (h_active && v_active) ? h_cnt : '0;
            y           <= (h_active && v_active) ? v_cnt : '0;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            busy        <= 1'b1;
        end
    end

endmodule

`default_nettype wire
